// File: rtl/phys_mem_ctrl_if.sv
// CPU-side physical-memory bus between the CPU top (master) and phys_mem_ctrl (slave).
interface phys_mem_ctrl_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_is_write;
  logic [31:0] mem_rdata;
  logic        mem_busy;

  modport master (
    output mem_addr, mem_wdata, mem_is_write,
    input  mem_rdata, mem_busy
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_is_write,
    output mem_rdata, mem_busy
  );
endinterface

// File: rtl/phys_mem_ctrl.sv
// Physical-memory responder: turns CPU requests into wait-stated async SRAM cycles.
// Define MEMCTL_ROM_EN to map a read-only synchronous boot ROM window at 0x1FC00000.
module phys_mem_ctrl #(
  parameter int ADDR_WIDTH  = 20,
  parameter int WAIT_CYCLES = 2,
  parameter int ROM_AW      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  phys_mem_ctrl_if.slave        mem,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [31:0]           ram_dq_in,
  output logic [31:0]           ram_dq_out,
  output logic                  ram_dq_oe,
  output logic                  ram_ce_n,
  output logic                  ram_oe_n,
  output logic                  ram_we_n,
  output logic [ROM_AW-1:0]     rom_addr,
  input  logic [31:0]           rom_data
);

  // state  | meaning
  // IDLE   | strobes off, waiting for a request tuple that differs from the last one
  // SETUP  | address/ce valid; oe for reads, data driven for writes
  // ACCESS | WAIT_CYCLES strobe cycles; read data captured on the last one
  // HOLD   | write only: we released, data and ce still driven
  // ROMRD  | boot ROM read, rom_data captured at end of cycle
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, ROMRD} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [29:0] addr_q;
  logic        wr_q;
  logic [31:0] wdata_q;
  logic        last_valid;
  logic [3:0]  cnt;
  logic [31:0] rdata_q;
  logic        diff;
  logic        is_ram;
  logic        is_rom;

  // wdata only distinguishes requests when the current request is a write
  assign diff = !last_valid
              || (mem.mem_addr[31:2] != addr_q)
              || (mem.mem_is_write != wr_q)
              || (mem.mem_is_write && (mem.mem_wdata != wdata_q));

  assign is_ram = (mem.mem_addr[31:ADDR_WIDTH+2] == '0);

`ifdef MEMCTL_ROM_EN
  localparam logic [31:0] ROM_BASE = 32'h1FC0_0000;
  logic unused_bits;
  assign is_rom      = !is_ram && (mem.mem_addr[31:ROM_AW+2] == ROM_BASE[31:ROM_AW+2]);
  // Address is presented in cycle 0 so the synchronous ROM has data by the end of ROMRD.
  assign rom_addr    = (state == IDLE) ? mem.mem_addr[ROM_AW+1:2] : addr_q[ROM_AW-1:0];
  assign unused_bits = ^mem.mem_addr[1:0];
`else
  logic unused_bits;
  assign is_rom      = 1'b0;
  assign rom_addr    = '0;
  assign unused_bits = ^{mem.mem_addr[1:0], rom_data};
`endif

  assign mem.mem_busy  = (state != IDLE) || diff;
  assign mem.mem_rdata = rdata_q;
  assign ram_dq_out    = wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_valid <= 1'b0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      cnt        <= '0;
      ram_addr   <= '0;
      rdata_q    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && diff) begin
        addr_q     <= mem.mem_addr[31:2];
        wr_q       <= mem.mem_is_write;
        wdata_q    <= mem.mem_wdata;
        last_valid <= 1'b1;
        if (is_ram)
          ram_addr <= mem.mem_addr[ADDR_WIDTH+1:2];
        else if (!is_rom && !mem.mem_is_write)
          rdata_q <= '0;
      end
      if (state == SETUP)
        cnt <= CNT_LOAD;
      else if (state == ACCESS && cnt != '0)
        cnt <= cnt - 4'd1;
      if (state == ACCESS && cnt == '0 && !wr_q)
        rdata_q <= ram_dq_in;
`ifdef MEMCTL_ROM_EN
      if (state == ROMRD)
        rdata_q <= rom_data;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    ram_ce_n  = 1'b1;
    ram_oe_n  = 1'b1;
    ram_we_n  = 1'b1;
    ram_dq_oe = 1'b0;
    unique case (state)
      IDLE: begin
        if (diff) begin
          if (is_ram)
            state_nxt = SETUP;
          else if (is_rom && !mem.mem_is_write)
            state_nxt = ROMRD;
        end
      end
      SETUP: begin
        ram_ce_n  = 1'b0;
        ram_oe_n  = wr_q;
        ram_dq_oe = wr_q;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        ram_ce_n  = 1'b0;
        ram_oe_n  = wr_q;
        ram_we_n  = !wr_q;
        ram_dq_oe = wr_q;
        if (cnt == '0)
          state_nxt = wr_q ? HOLD : IDLE;
      end
      HOLD: begin
        ram_ce_n  = 1'b0;
        ram_dq_oe = 1'b1;
        state_nxt = IDLE;
      end
      ROMRD:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_phys_mem_ctrl.sv
// Directed bench for phys_mem_ctrl (WAIT_CYCLES = 2) with a small SRAM and sync ROM model.
module tb_phys_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] ram_addr;
  logic [31:0] ram_dq_in;
  logic [31:0] ram_dq_out;
  logic        ram_dq_oe;
  logic        ram_ce_n;
  logic        ram_oe_n;
  logic        ram_we_n;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data = '0;

  logic [31:0] sram [0:255];
  int n_cmp = 0;
  int n_err = 0;
  int busy_cyc, ce_cyc, ce_starts, we_cyc, oe_cyc;
  logic [31:0] we_data;
  logic prev_ce;

  phys_mem_ctrl_if bus ();

  phys_mem_ctrl #(.ADDR_WIDTH(20), .WAIT_CYCLES(2), .ROM_AW(10)) dut (
    .clk(clk), .rst(rst), .mem(bus.slave),
    .ram_addr(ram_addr), .ram_dq_in(ram_dq_in), .ram_dq_out(ram_dq_out),
    .ram_dq_oe(ram_dq_oe), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  assign ram_dq_in = (!ram_ce_n && !ram_oe_n) ? sram[ram_addr[7:0]] : 32'h0;

  always @(posedge clk) rom_data <= 32'hCAFE_0000 | 32'(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    busy_cyc = 0; ce_cyc = 0; ce_starts = 0; we_cyc = 0; oe_cyc = 0;
    we_data = '0; prev_ce = 1'b1;
  endtask

  // Sample at negedge; the SRAM model latches data while we_n is low.
  task automatic sample();
    if (bus.mem_busy) busy_cyc++;
    if (!ram_ce_n) ce_cyc++;
    if (!ram_ce_n && prev_ce) ce_starts++;
    prev_ce = ram_ce_n;
    if (ram_dq_oe) oe_cyc++;
    if (!ram_we_n) begin
      we_cyc++;
      we_data = ram_dq_out;
      if (!ram_ce_n) sram[ram_addr[7:0]] = ram_dq_out;
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample();
      @(posedge clk); #1;
    end
  endtask

  task automatic access(input int maxc);
    bit done = 0;
    for (int i = 0; i < maxc && !done; i++) begin
      @(negedge clk);
      sample();
      if (!bus.mem_busy) done = 1;
      @(posedge clk); #1;
    end
    if (!done) chk("busy_timeout", 32'd0, 32'd1);
  endtask

  task automatic req(input logic [31:0] a, input logic w, input logic [31:0] d);
    bus.mem_addr = a; bus.mem_is_write = w; bus.mem_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = '0;
    sram[4] = 32'hDEAD_BEEF;
    rst = 1'b1;
    req(32'h0000_0010, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.mem_busy), 32'd1);
    chk("rst_ce_n", 32'(ram_ce_n), 32'd1);
    chk("rst_rdata", bus.mem_rdata, 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);

    @(posedge clk); #1 rst = 1'b0;
    clr(); access(20);
    chk("rd0_busy", busy_cyc, 4);
    chk("rd0_rdata", bus.mem_rdata, 32'hDEAD_BEEF);
    chk("rd0_ram_addr", 32'(ram_addr), 32'd4);
    chk("rd0_ce_starts", ce_starts, 1);

    req(32'h0000_0020, 1'b1, 32'h1234_5678);
    clr(); access(20);
    chk("wr_busy", busy_cyc, 5);
    chk("wr_we_cyc", we_cyc, 2);
    chk("wr_dq_oe_cyc", oe_cyc, 4);
    chk("wr_ce_cyc", ce_cyc, 4);
    chk("wr_dq_out", we_data, 32'h1234_5678);
    chk("wr_ram_addr", 32'(ram_addr), 32'd8);
    chk("wr_sram", sram[8], 32'h1234_5678);
    chk("wr_rdata_kept", bus.mem_rdata, 32'hDEAD_BEEF);

    clr(); run_cycles(20);
    chk("idle_busy", busy_cyc, 0);
    chk("idle_ce", ce_cyc, 0);

    req(32'h0000_0020, 1'b1, 32'hA5A5_A5A5);
    clr(); access(20);
    chk("wr2_busy", busy_cyc, 5);
    chk("wr2_sram", sram[8], 32'hA5A5_A5A5);

    req(32'h0000_0020, 1'b0, 32'hA5A5_A5A5);
    clr(); access(20);
    chk("rd1_busy", busy_cyc, 4);
    chk("rd1_rdata", bus.mem_rdata, 32'hA5A5_A5A5);

    req(32'h8000_0000, 1'b0, 32'h0);
    clr(); access(20);
    chk("unm_rd_busy", busy_cyc, 1);
    chk("unm_rd_ce", ce_cyc, 0);
    chk("unm_rd_rdata", bus.mem_rdata, 32'h0);

    req(32'h8000_0000, 1'b1, 32'h7777_7777);
    clr(); access(20);
    chk("unm_wr_busy", busy_cyc, 1);
    chk("unm_wr_ce", ce_cyc, 0);
    chk("unm_wr_rdata", bus.mem_rdata, 32'h0);

    req(32'h0000_0010, 1'b0, 32'h0);
    clr(); run_cycles(2);
    req(32'h0000_0020, 1'b0, 32'h0);
    run_cycles(2);
    chk("mid_first_rdata", bus.mem_rdata, 32'hDEAD_BEEF);
    chk("mid_busy_at_idle", 32'(bus.mem_busy), 32'd1);
    access(20);
    chk("mid_busy_total", busy_cyc, 8);
    chk("mid_ce_starts", ce_starts, 2);
    chk("mid_second_rdata", bus.mem_rdata, 32'hA5A5_A5A5);

    req(32'h1FC0_0004, 1'b0, 32'h0);
    clr(); access(20);
    chk("rom_rd_ce", ce_cyc, 0);
`ifdef MEMCTL_ROM_EN
    chk("rom_rd_busy", busy_cyc, 2);
    chk("rom_rd_rdata", bus.mem_rdata, 32'hCAFE_0001);
    chk("rom_addr", 32'(rom_addr), 32'd1);
`else
    chk("rom_rd_busy", busy_cyc, 1);
    chk("rom_rd_rdata", bus.mem_rdata, 32'h0);
    chk("rom_addr_tied", 32'(rom_addr), 32'd0);
`endif

    req(32'h1FC0_0004, 1'b1, 32'h0BAD_F00D);
    clr(); access(20);
    chk("rom_wr_busy", busy_cyc, 1);
    chk("rom_wr_ce", ce_cyc, 0);

    req(32'h0000_0030, 1'b1, 32'h0000_0055);
    clr(); run_cycles(3);
    rst = 1'b1;
    #1;
    chk("abort_we_n", 32'(ram_we_n), 32'd1);
    chk("abort_ce_n", 32'(ram_ce_n), 32'd1);
    chk("abort_dq_oe", 32'(ram_dq_oe), 32'd0);
    chk("abort_busy", 32'(bus.mem_busy), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    clr(); access(20);
    chk("retry_busy", busy_cyc, 5);
    chk("retry_sram", sram[12], 32'h0000_0055);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/phys_mem_ctrl.md
Name: phys_mem_ctrl

Overview:
- Responder end of the CPU physical-memory interface. The CPU side presents address, write data and a write flag; this block returns read data and a busy flag.
- Translates each request into a multi-cycle access on an external asynchronous 32-bit SRAM, with programmable wait states.
- Decodes unmapped addresses and, optionally, a boot ROM window.
- Sits between the CPU top and the board SRAM pins.

Parameters:
- ADDR_WIDTH, 20: SRAM word-address width. RAM region is byte addresses 0 .. (4<<ADDR_WIDTH)-1.
- WAIT_CYCLES, 2: number of strobe-active cycles per SRAM access; legal range 1..15.
- ROM_AW, 10: ROM word-address width (used only with the optional feature).

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- mem_addr  in  32  byte address from CPU; bits [1:0] are ignored.
- mem_wdata  in  32  write data from CPU.
- mem_is_write  in  1  1 = write request, 0 = read request.
- mem_rdata  out  32  read data returned to CPU.
- mem_busy  out  1  high while a request is outstanding.
- ram_addr  out  ADDR_WIDTH  SRAM word address.
- ram_dq_in  in  32  SRAM data bus, read direction.
- ram_dq_out  out  32  SRAM data bus, write direction.
- ram_dq_oe  out  1  drive enable for ram_dq_out.
- ram_ce_n  out  1  SRAM chip enable, active low.
- ram_oe_n  out  1  SRAM output enable, active low.
- ram_we_n  out  1  SRAM write enable, active low.
- rom_addr  out  ROM_AW  synchronous ROM word address (MEMCTL_ROM_EN only).
- rom_data  in  32  ROM read data, valid one cycle after rom_addr (MEMCTL_ROM_EN only).

Behaviour:
- No request strobe. A new request is the current tuple {mem_addr[31:2], mem_is_write, mem_wdata (writes only)} differing from the last serviced tuple, or last_valid=0.
- Call this compare "diff". It is evaluated only in IDLE.
- Repeated identical reads and writes are not re-executed.
- mem_busy = (state != IDLE) | diff. It is combinational, so it rises in the same cycle the request changes (cycle 0).
- At the end of cycle 0 the tuple is latched into the serviced registers, last_valid is set to 1, and the region is decoded.
- Input changes while state != IDLE are ignored until the return to IDLE. At that point they produce a new diff.

Reset:
- state = IDLE, last_valid = 0, mem_rdata = 0, ram_addr = 0.
- ram_ce_n, ram_oe_n, ram_we_n = 1; ram_dq_oe = 0.
- mem_busy reads 1 during and after reset until the first access completes.
- An assertion mid-access forces all strobes inactive immediately. The aborted SRAM word is undefined.

States:
- IDLE: strobes inactive.
- SETUP (1 cycle): ram_addr driven, ram_ce_n = 0. Read: ram_oe_n = 0. Write: ram_dq_oe = 1, ram_dq_out = data, ram_we_n = 1.
- ACCESS (WAIT_CYCLES cycles, 4-bit down-counter): read holds oe; write drives ram_we_n = 0. On the last read cycle, ram_dq_in is captured into mem_rdata.
- HOLD (writes only, 1 cycle): ram_we_n = 1, data and ce still driven.
- ROMRD (1 cycle): rom_addr driven.

Timing (W = WAIT_CYCLES):
- RAM read: busy in cycles 0..W+1; mem_rdata valid and busy low from cycle W+2.
- RAM write: busy in cycles 0..W+2; low from cycle W+3.
- Unmapped read: busy in cycle 0 only; mem_rdata = 0 from cycle 1.
- Unmapped write: busy in cycle 0 only; discarded.
- mem_rdata holds its value until the next read completes. Writes never modify it.

Optional Feature:
- Macro: MEMCTL_ROM_EN.
- With it defined: byte range 0x1FC00000 .. 0x1FC00000+(4<<ROM_AW)-1 is a read-only ROM region.
  - Read: IDLE → ROMRD with rom_addr = addr[ROM_AW+1:2]. rom_data is captured at the end of ROMRD. Busy in cycles 0..1; data valid from cycle 2.
  - Write: ignored, with unmapped-write timing.
- Without it: this range decodes as unmapped, and rom_addr is tied to 0.

Test Plan (W = 2):
- Reset release with mem_addr = 0x00000010 (read) and ram_dq_in = 0xDEADBEEF → busy stays 1 through the third cycle after release; then busy = 0 and mem_rdata = 0xDEADBEEF.
- Write 0x12345678 to 0x00000020 → ram_addr = 8; ram_we_n low for exactly 2 cycles with ram_dq_out = 0x12345678 and dq_oe spanning SETUP..HOLD; busy high for 5 cycles.
- Identical request held for 20 cycles after completion → busy stays 0 and no ce_n activity. Changing only mem_wdata on a write → a new 5-cycle write.
- Read 0x80000000 (unmapped) → busy for 1 cycle, mem_rdata = 0, SRAM strobes never asserted.
- Change mem_addr mid-read (cycle 2) → first read completes unchanged; busy stays high and a second read of the new address starts in the cycle after IDLE is reached.
- MEMCTL_ROM_EN, read 0x1FC00004 with rom_data = 0xCAFE0001 → rom_addr = 1, busy for 2 cycles, mem_rdata = 0xCAFE0001. A write to the same address leaves the SRAM untouched.
